hilo_muldiv_sequencer: RTL and testbench
========================================

HILO_MULDIV_SEQUENCER -- requirements
Module: hilo_muldiv_sequencer

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port Rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port Start, input, 1 bit: Op/OpA/OpB valid from EX this cycle.
REQ-004 SHALL have port Op, input, 3 bits: operation code (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MADD=6, MSUB=7).
REQ-005 SHALL have ports OpA and OpB, input, 32 bits each: rs and rt operand values.
REQ-006 SHALL have port ReadReq, input, 1 bit: MFHI or MFLO occupies EX this cycle.
REQ-007 SHALL have port Stall, output, 1 bit: freeze IF/ID/EX this cycle.
REQ-008 SHALL have port Busy, output, 1 bit: an iterative operation is in progress.
REQ-009 SHALL have port Done, output, 1 bit: one-cycle pulse after a HI/LO update by an iterative operation.
REQ-010 SHALL have ports Hi and Lo, output, 32 bits each: architectural HI and LO registers.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and FIX.
REQ-012 SHALL accept Start only in IDLE; a Start in RUN or FIX is not accepted, and the requester holds it while stalled.
REQ-013 SHALL, for MTHI/MTLO accepted at edge T, write OpA to Hi/Lo at edge T, stay in IDLE, keep Busy low and not pulse Done.
REQ-014 SHALL, for MULT/MULTU/DIV/DIVU/MADD/MSUB accepted at edge T: RUN for 32 cycles (5-bit counter 31 down to 0), then FIX for 1 cycle; Hi/Lo update at edge T+33; Busy high after edge T through edge T+33; Done high during the cycle after edge T+33.
REQ-015 SHALL execute multiplies as shift-add on operand magnitudes, with signed ops negating the 64-bit product in FIX when the operand signs differ.
REQ-016 SHALL execute divides as restoring division on magnitudes; signed quotient is negative when signs differ, and signed remainder takes the dividend's sign.
REQ-017 SHALL, on divide by zero (DIV or DIVU), give Lo=0xFFFFFFFF and Hi=OpA, with no sign fix.
REQ-018 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, give Lo=0x80000000 and Hi=0.
REQ-019 SHALL drive Stall = Busy & (ReadReq | Start), combinationally.
REQ-020 SHALL keep Hi/Lo stable throughout RUN and FIX.

Reset
REQ-021 SHALL, while Rst is high, force state IDLE, counter 0, Hi=0, Lo=0, Busy=0, Done=0 and Stall=0, regardless of the clock.
REQ-022 SHALL, on Rst asserted mid-RUN or mid-FIX, abort the operation, discard partial results and produce no Done.

Configuration
REQ-023 SHALL, with macro MULDIV_MADD_EN defined, implement MADD/MSUB as a signed 64-bit product added to or subtracted from {Hi,Lo} at edge T+33, wrapping modulo 2^64.
REQ-024 SHALL, without MULDIV_MADD_EN, treat Op 6/7 as no-ops: accepted in IDLE, no state change, no Busy, no Done, Hi/Lo unchanged.

Structure
REQ-025 SHALL place the Op encodings, the FSM state encoding and the constant ITER_COUNT=32 in a shared package muldiv_pkg.
REQ-026 SHALL place a single iteration step (one shift-add or one restoring-subtract) in sub-module muldiv_iter_core; the FSM, counter, sign fix and HI/LO registers stay in the top.

Verification
REQ-027 SHALL cover: MULT 0xFFFFFFFF x 0x00000002 -> after 33 edges Hi=0xFFFFFFFF, Lo=0xFFFFFFFE, Done pulses once.
REQ-028 SHALL cover: MULTU 0xFFFFFFFF x 0x00000002 -> Hi=0x00000001, Lo=0xFFFFFFFE.
REQ-029 SHALL cover: DIV -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU 7 / 0 -> Lo=0xFFFFFFFF, Hi=0x00000007.
REQ-030 SHALL cover: ReadReq or a second Start held during RUN -> Stall high on every one of those cycles; second Start accepted at the first edge in IDLE.
REQ-031 SHALL cover: Rst pulsed at RUN cycle 10 -> Hi=Lo=0, Busy=0, no Done, next MTLO 0x1234 -> Lo=0x00001234 at that edge.
REQ-032 SHALL cover, with MULDIV_MADD_EN: {Hi,Lo}=0x00000000_00000005, MADD 3 x -2 -> {Hi,Lo}=0xFFFFFFFF_FFFFFFFF; without the macro -> {Hi,Lo} unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ITER_COUNT = 32;
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Operations that work on operand magnitudes and fix the sign afterwards
    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration of either shift-add multiply or restoring divide on a {hi,lo} pair.
module muldiv_iter_core
    import muldiv_pkg::*;
(
    input  logic              is_div,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   shifted;
    logic              fits;
    logic [DATA_W-1:0] rem;

    // Multiply: add operand when multiplier LSB set, then shift {sum,lo} right.
    // Divide: shift remainder left taking next dividend bit, subtract if it fits.
    always_comb begin
        sum     = {1'b0, hi_in} + {1'b0, (lo_in[0] ? operand : '0)};
        shifted = {hi_in, lo_in[DATA_W-1]};
        fits    = (shifted >= {1'b0, operand});
        rem     = shifted[DATA_W-1:0] - operand;
        hi_out  = sum[DATA_W:1];
        lo_out  = {sum[0], lo_in[DATA_W-1:1]};
        if (is_div) begin
            hi_out = fits ? rem : shifted[DATA_W-1:0];
            lo_out = {lo_in[DATA_W-2:0], fits};
        end
    end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit with pipeline stall generation.
// Optional feature: define MULDIV_MADD_EN to enable MADD/MSUB accumulation.
module hilo_muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [DATA_W-1:0] OpA,
    input  logic [DATA_W-1:0] OpB,
    input  logic              ReadReq,
    output logic              Stall,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [DATA_W-1:0] mag_b_q, mag_b_d, opa_q, opa_d;
    op_e               op_q, op_d;
    logic              neg_p_q, neg_p_d, neg_r_q, neg_r_d;
    logic [DATA_W-1:0] hi_d, lo_d;
    logic              busy_d, done_d;

    op_e                 op_in;
    logic                in_signed, in_iter;
    logic [DATA_W-1:0]   mag_a_in, mag_b_in;
    logic                run_div;
    logic [DATA_W-1:0]   step_hi, step_lo;
    logic [2*DATA_W-1:0] prod_raw, prod_fix, hilo;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    // Decode the incoming request and take operand magnitudes
    always_comb begin
        op_in     = op_e'(Op);
        in_signed = op_is_signed(op_in);
        mag_a_in  = (in_signed && OpA[DATA_W-1]) ? -OpA : OpA;
        mag_b_in  = (in_signed && OpB[DATA_W-1]) ? -OpB : OpB;
`ifdef MULDIV_MADD_EN
        in_iter   = (op_in != OP_MTHI) && (op_in != OP_MTLO);
`else
        in_iter   = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
                    (op_in == OP_DIV)  || (op_in == OP_DIVU);
`endif
    end

    assign run_div = op_is_div(op_q);

    muldiv_iter_core u_core (
        .is_div  (run_div),
        .hi_in   (acc_hi_q),
        .lo_in   (acc_lo_q),
        .operand (mag_b_q),
        .hi_out  (step_hi),
        .lo_out  (step_lo)
    );

    // Sign-corrected results used at writeback
    always_comb begin
        prod_raw = {acc_hi_q, acc_lo_q};
        prod_fix = neg_p_q ? -prod_raw : prod_raw;
        hilo     = {Hi, Lo};
        quo_fix  = neg_p_q ? -acc_lo_q : acc_lo_q;
        rem_fix  = neg_r_q ? -acc_hi_q : acc_hi_q;
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mag_b_d  = mag_b_q;
        opa_d    = opa_q;
        op_d     = op_q;
        neg_p_d  = neg_p_q;
        neg_r_d  = neg_r_q;
        hi_d     = Hi;
        lo_d     = Lo;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (op_in == OP_MTHI) begin
                        hi_d = OpA;
                    end else if (op_in == OP_MTLO) begin
                        lo_d = OpA;
                    end else if (in_iter) begin
                        state_d  = ST_RUN;
                        cnt_d    = CNT_W'(ITER_COUNT - 1);
                        acc_hi_d = '0;
                        acc_lo_d = mag_a_in;
                        mag_b_d  = mag_b_in;
                        opa_d    = OpA;
                        op_d     = op_in;
                        neg_p_d  = in_signed & (OpA[DATA_W-1] ^ OpB[DATA_W-1]);
                        neg_r_d  = in_signed & OpA[DATA_W-1];
                    end
                end
            end
            ST_RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                case (op_q)
                    OP_MULT, OP_MULTU: {hi_d, lo_d} = prod_fix;
                    OP_DIV, OP_DIVU: begin
                        if (mag_b_q == '0) begin
                            hi_d = opa_q;
                            lo_d = '1;
                        end else begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end
                    end
`ifdef MULDIV_MADD_EN
                    OP_MADD: {hi_d, lo_d} = hilo + prod_fix;
                    OP_MSUB: {hi_d, lo_d} = hilo - prod_fix;
`endif
                    default: {hi_d, lo_d} = hilo;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and register update with asynchronous reset
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mag_b_q  <= '0;
            opa_q    <= '0;
            op_q     <= OP_MULT;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mag_b_q  <= mag_b_d;
            opa_q    <= opa_d;
            op_q     <= op_d;
            neg_p_q  <= neg_p_d;
            neg_r_q  <= neg_r_d;
            Hi       <= hi_d;
            Lo       <= lo_d;
            Busy     <= busy_d;
            Done     <= done_d;
        end
    end

    // Freeze the front of the pipe while an iterative op owns HI/LO
    assign Stall = Busy & (ReadReq | Start);

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Self-checking bench for hilo_muldiv_sequencer (honours MULDIV_MADD_EN).
module tb_hilo_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        Clk, Rst, Start, ReadReq;
    logic [2:0]  Op;
    logic [31:0] OpA, OpB;
    logic        Stall, Busy, Done;
    logic [31:0] Hi, Lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    hilo_muldiv_sequencer dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
        .ReadReq(ReadReq), .Stall(Stall), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_iter(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
        return (op != OP_MTHI) && (op != OP_MTLO);
`else
        return op <= 3'd3;
`endif
    endfunction

    // Architectural result of one instruction, from plain arithmetic
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        logic signed [31:0] sa, sb, q, r;
        logic signed [63:0] ea, eb, p;
        sa = a; sb = b; ea = sa; eb = sb; p = ea * eb;
        case (op)
            OP_MULT:  return p;
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb; r = sa % sb;
                return {r, q};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            OP_MTHI: return {a, hl[31:0]};
            OP_MTLO: return {hl[63:32], a};
`ifdef MULDIV_MADD_EN
            OP_MADD: return hl + p;
            OP_MSUB: return hl - p;
`endif
            default: return hl;
        endcase
    endfunction

    // Issue one instruction, follow it to completion and check HI/LO and handshakes
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int lat;
        exp = model(op, a, b, {m_hi, m_lo});
        @(negedge Clk);
        Start = 1'b1; Op = op; OpA = a; OpB = b;
        @(posedge Clk); #1;
        Start = 1'b0;
        if (is_iter(op)) begin
            chk("busy_after_start", 64'(Busy), 64'd1);
            lat = 0;
            while (Done !== 1'b1 && lat < 40) begin
                chk("hilo_hold", {Hi, Lo}, {m_hi, m_lo});
                @(posedge Clk); #1;
                lat++;
            end
            chk("done_latency", 64'(lat), 64'd33);
            chk("busy_at_done", 64'(Busy), 64'd0);
        end else begin
            chk("busy_noiter", 64'(Busy), 64'd0);
            chk("done_noiter", 64'(Done), 64'd0);
        end
        {m_hi, m_lo} = exp;
        chk("hilo_result", {Hi, Lo}, exp);
        if (is_iter(op)) begin
            @(posedge Clk); #1;
            chk("done_single", 64'(Done), 64'd0);
        end
    endtask

    initial begin
        int done_seen;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        Rst = 1'b1; Start = 1'b0; ReadReq = 1'b1; Op = 3'd0; OpA = '0; OpB = '0;
        m_hi = '0; m_lo = '0;
        @(posedge Clk); @(posedge Clk); #1;
        chk("reset_hilo", {Hi, Lo}, 64'd0);
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_done", 64'(Done), 64'd0);
        chk("reset_stall", 64'(Stall), 64'd0);
        @(negedge Clk); Rst = 1'b0; ReadReq = 1'b0;

        // Directed arithmetic corners
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("mult_m1x2", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("multu_ffx2", {Hi, Lo}, 64'h0000_0001_FFFF_FFFE);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        chk("div_m7_2", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(OP_DIVU, 32'h0000_0007, 32'h0000_0000);
        chk("divu_by0", {Hi, Lo}, 64'h0000_0007_FFFF_FFFF);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0000);
        chk("div_by0_signed", {Hi, Lo}, 64'hFFFF_FFF9_FFFF_FFFF);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf", {Hi, Lo}, 64'h0000_0000_8000_0000);

        // Accumulate path
        run_op(OP_MTHI, 32'h0, 32'h0);
        run_op(OP_MTLO, 32'h5, 32'h0);
        chk("mt_setup", {Hi, Lo}, 64'h0000_0000_0000_0005);
        run_op(OP_MADD, 32'h3, 32'hFFFF_FFFE);
`ifdef MULDIV_MADD_EN
        chk("madd_3xm2", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        chk("madd_noop", {Hi, Lo}, 64'h0000_0000_0000_0005);
`endif

        // Second Start and ReadReq held while busy
        @(negedge Clk);
        Start = 1'b1; Op = OP_MULTU; OpA = 32'hFFFF_FFFF; OpB = 32'h2;
        @(posedge Clk); #1;
        Op = OP_MTLO; OpA = 32'h0000_00AB; OpB = '0;
        for (int k = 0; k < 33; k++) begin
            ReadReq = 1'($urandom_range(0, 1));
            #1;
            chk("stall_held", 64'(Stall), 64'd1);
            @(posedge Clk); #1;
        end
        ReadReq = 1'b0;
        chk("stall_done_done", 64'(Done), 64'd1);
        chk("stall_done_busy", 64'(Busy), 64'd0);
        chk("stall_done_stall", 64'(Stall), 64'd0);
        chk("stall_done_hilo", {Hi, Lo}, 64'h0000_0001_FFFF_FFFE);
        @(posedge Clk); #1;
        Start = 1'b0;
        m_hi = 32'h1; m_lo = 32'hAB;
        chk("second_start_hilo", {Hi, Lo}, {m_hi, m_lo});
        chk("second_start_done", 64'(Done), 64'd0);
        ReadReq = 1'b1; #1;
        chk("readreq_idle", 64'(Stall), 64'd0);
        ReadReq = 1'b0;

        // Reset in the middle of RUN
        @(negedge Clk);
        Start = 1'b1; Op = OP_MULT; OpA = 32'h1234_5678; OpB = 32'h9ABC_DEF0;
        @(posedge Clk); #1;
        Start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 5) begin
                ReadReq = 1'b1; #1;
                chk("readreq_run", 64'(Stall), 64'd1);
            end
            @(posedge Clk); #1;
        end
        #1 Rst = 1'b1;
        #1;
        chk("midrst_hilo", {Hi, Lo}, 64'd0);
        chk("midrst_busy", 64'(Busy), 64'd0);
        chk("midrst_done", 64'(Done), 64'd0);
        chk("midrst_stall", 64'(Stall), 64'd0);
        @(negedge Clk); Rst = 1'b0; ReadReq = 1'b0;
        m_hi = '0; m_lo = '0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clk); #1;
            if (Done === 1'b1) done_seen++;
        end
        chk("midrst_no_done", 64'(done_seen), 64'd0);
        run_op(OP_MTLO, 32'h0000_1234, 32'h0);
        chk("after_rst_mtlo", {Hi, Lo}, 64'h0000_0000_0000_1234);

        // Randomized instruction stream
        for (int n = 0; n < 24; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
